// File: rtl/exmem_pkg.sv
// exmem_pkg: shared constants and types for the
// two-requester user-area memory arbiter.
package exmem_pkg;

  localparam int MEM_N = 10;
  localparam int LAT = MEM_N + 1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/exmem_tag_pipe.sv
// exmem_tag_pipe: shift register of owner tags that
// lines up with the fixed-latency memory ack.
module exmem_tag_pipe
  import exmem_pkg::*;
#(
  parameter int DEPTH = LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  output logic head_valid,
  output logic head_id
);

  tag_t [DEPTH-1:0] pipe;
  tag_t             tag_in;

  assign tag_in = '{valid: push, id: push & push_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], tag_in};
    end
  end

  assign head_valid = pipe[DEPTH-1].valid;
  assign head_id = pipe[DEPTH-1].id;

endmodule

// File: rtl/exmem_arbiter.sv
// exmem_arbiter: shares one pipelined memory between
// fetch (M0) and data (M1) Wishbone requesters.
module exmem_arbiter
  import exmem_pkg::*;
#(
  parameter int N = MEM_N,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack,
  output logic [31:0] m1_dat_o,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_dat_o,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat_i,
  output logic        err
);

  logic pend0;
  logic pend1;
  logic last_grant;
  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic head_valid;
  logic head_id;
  logic drop0;
  logic drop1;
  logic fault;

  // Gating with rst_n keeps every output low during reset.
  assign elig0 = m0_stb & ~pend0 & rst_n;
  assign elig1 = m1_stb & ~pend1 & rst_n;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (elig0 & elig1): begin
        if (ARB_MODE == ARB_FIXED || last_grant == M1)
          gnt0 = 1'b1;
        else
          gnt1 = 1'b1;
      end
      (elig0 & ~elig1): gnt0 = 1'b1;
      (~elig0 & elig1): gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign mem_stb = gnt0 | gnt1;

  always_comb begin
    mem_we = 1'b0;
    mem_sel = '0;
    mem_adr = '0;
    mem_dat_o = '0;
    unique case (1'b1)
      gnt0: begin
        mem_we = m0_we;
        mem_sel = m0_sel;
        mem_adr = m0_adr;
        mem_dat_o = m0_dat_i;
      end
      gnt1: begin
        mem_we = m1_we;
        mem_sel = m1_sel;
        mem_adr = m1_adr;
        mem_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  exmem_tag_pipe #(
    .DEPTH(N + 1)
  ) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(mem_stb),
    .push_id(gnt1),
    .head_valid(head_valid),
    .head_id(head_id)
  );

  assign m0_ack = mem_ack & head_valid & (head_id == M0);
  assign m1_ack = mem_ack & head_valid & (head_id == M1);
  assign m0_dat_o = rst_n ? mem_dat_i : '0;
  assign m1_dat_o = rst_n ? mem_dat_i : '0;

  // A missing ack still frees its owner so the stb retries.
  assign drop0 = head_valid & ~mem_ack & (head_id == M0);
  assign drop1 = head_valid & ~mem_ack & (head_id == M1);
  assign fault = mem_ack ^ head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      last_grant <= M1;
      err <= 1'b0;
    end else begin
      pend0 <= (pend0 & ~m0_ack & ~drop0) | gnt0;
      pend1 <= (pend1 & ~m1_ack & ~drop1) | gnt1;
      if (mem_stb)
        last_grant <= gnt1;
      err <= err | fault;
    end
  end

endmodule

// File: tb/tb_exmem_arbiter.sv
// Bench for exmem_arbiter: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_exmem_arbiter;

  localparam int N = 10;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb  [2][2];
  logic        we   [2][2];
  logic [3:0]  sel  [2][2];
  logic [31:0] adr  [2][2];
  logic [31:0] wdat [2][2];
  logic        ack  [2][2];
  logic [31:0] rdat [2][2];
  logic        mem_stb [2];
  logic        mem_we  [2];
  logic [3:0]  mem_sel [2];
  logic [31:0] mem_adr [2];
  logic [31:0] mem_wdat[2];
  logic        mem_ack [2];
  logic [31:0] mem_rdat[2];
  logic        err     [2];
  logic        kill    [2];
  logic        force_ack[2];

  int checks = 0;
  int failures = 0;
  int m0_log[$];
  int m1_log[$];

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] word_adr(input int w);
    return 32'h3800_0000 | (32'(w) << 2);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    exmem_arbiter #(.N(N), .ARB_MODE(d)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_stb(stb[d][0]), .m0_we(we[d][0]),
      .m0_sel(sel[d][0]), .m0_adr(adr[d][0]),
      .m0_dat_i(wdat[d][0]), .m0_ack(ack[d][0]),
      .m0_dat_o(rdat[d][0]),
      .m1_stb(stb[d][1]), .m1_we(we[d][1]),
      .m1_sel(sel[d][1]), .m1_adr(adr[d][1]),
      .m1_dat_i(wdat[d][1]), .m1_ack(ack[d][1]),
      .m1_dat_o(rdat[d][1]),
      .mem_stb(mem_stb[d]), .mem_we(mem_we[d]),
      .mem_sel(mem_sel[d]), .mem_adr(mem_adr[d]),
      .mem_dat_o(mem_wdat[d]), .mem_ack(mem_ack[d]),
      .mem_dat_i(mem_rdat[d]), .err(err[d])
    );

    // Fixed-latency memory: ack and data LAT cycles after stb.
    logic        pv    [LAT];
    logic [31:0] pd    [LAT];
    logic [31:0] store [16];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < LAT; k++) begin
          pv[k] <= 1'b0;
          pd[k] <= '0;
        end
        for (int k = 0; k < 16; k++) store[k] <= init_word(k);
      end else begin
        pv[0] <= mem_stb[d];
        pd[0] <= store[mem_adr[d][5:2]];
        for (int k = 1; k < LAT; k++) begin
          pv[k] <= pv[k-1];
          pd[k] <= pd[k-1];
        end
        if (mem_stb[d] && mem_we[d])
          for (int b = 0; b < 4; b++)
            if (mem_sel[d][b])
              store[mem_adr[d][5:2]][8*b +: 8] <= mem_wdat[d][8*b +: 8];
      end
    end

    assign mem_ack[d] = (pv[LAT-1] & ~kill[d]) | force_ack[d];
    assign mem_rdat[d] = pd[LAT-1];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(input int d, input int i);
    stb[d][i] = 1'b0;
    we[d][i] = 1'b0;
    sel[d][i] = '0;
    adr[d][i] = '0;
    wdat[d][i] = '0;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      kill[d] = 1'b0;
      force_ack[d] = 1'b0;
      for (int i = 0; i < 2; i++) release_req(d, i);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drive(input int d, input int i, input logic w,
                       input logic [3:0] s, input int word,
                       input logic [31:0] data);
    stb[d][i] = 1'b1;
    we[d][i] = w;
    sel[d][i] = s;
    adr[d][i] = word_adr(word);
    wdat[d][i] = data;
  endtask

  // Bounded wait for ack[d][i]; ends at the start of the next cycle.
  task automatic wait_ack(input int d, input int i, input int budget,
                          output int lat, output logic [31:0] data,
                          output int nstb, output int first_stb,
                          output logic [31:0] first_adr,
                          output int other);
    lat = -1;
    data = '0;
    nstb = 0;
    first_stb = -1;
    first_adr = '0;
    other = 0;
    for (int k = 0; k < budget && lat < 0; k++) begin
      @(negedge clk);
      if (mem_stb[d]) begin
        if (first_stb < 0) begin
          first_stb = k;
          first_adr = mem_adr[d];
        end
        nstb++;
      end
      if (ack[d][1-i]) other++;
      if (ack[d][i]) begin
        lat = k;
        data = rdat[d][i];
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    logic [200:0] outs;
    idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) drive(d, i, 1'b1, 4'hF, 3, 32'h1234_5678);
    rst_n = 1'b0;
    next_cycle();
    for (int d = 0; d < 2; d++) begin
      outs = {mem_stb[d], mem_we[d], mem_sel[d], mem_adr[d], mem_wdat[d],
              ack[d][0], ack[d][1], rdat[d][0], rdat[d][1], err[d]};
      checks++;
      if (outs !== '0)
        $display("FAIL reset_outs dut%0d: got %h want 0", d, outs);
      if (outs !== '0) failures++;
    end
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mem_stb[d], err[d]} !== 2'b00) begin
        $display("FAIL reset_idle dut%0d: got %b want 00", d, {mem_stb[d], err[d]});
        failures++;
      end
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    int lat, nstb, fs, oth;
    logic [31:0] dat, fa;
    do_reset();
    drive(0, 0, 1'b0, 4'hF, 4, '0);
    wait_ack(0, 0, 20, lat, dat, nstb, fs, fa, oth);
    release_req(0, 0);
    checks++;
    if (lat !== 11) begin
      $display("FAIL single_lat: got %0d want 11", lat); failures++;
    end
    checks++;
    if (dat !== init_word(4)) begin
      $display("FAIL single_data: got %h want %h", dat, init_word(4)); failures++;
    end
    checks++;
    if (nstb !== 1 || fs !== 0 || fa !== 32'h3800_0010) begin
      $display("FAIL single_issue: got n=%0d at %0d adr %h want n=1 at 0 adr 38000010",
               nstb, fs, fa);
      failures++;
    end
    checks++;
    if (oth !== 0) begin
      $display("FAIL single_m1_ack: got %0d want 0", oth); failures++;
    end
  endtask

  task automatic test_dual_rr();
    int lat, nstb, fs, oth;
    logic [31:0] dat, fa;
    do_reset();
    drive(0, 0, 1'b0, 4'hF, 1, '0);
    drive(0, 1, 1'b0, 4'hF, 10, '0);
    wait_ack(0, 0, 20, lat, dat, nstb, fs, fa, oth);
    release_req(0, 0);
    checks++;
    if (lat !== 11 || dat !== init_word(1)) begin
      $display("FAIL dual_m0: got lat %0d dat %h want 11 %h", lat, dat, init_word(1));
      failures++;
    end
    checks++;
    if (nstb !== 2 || fs !== 0 || fa !== word_adr(1) || oth !== 0) begin
      $display("FAIL dual_order: got n=%0d first %0d adr %h m1acks %0d want 2 0 %h 0",
               nstb, fs, fa, oth, word_adr(1));
      failures++;
    end
    wait_ack(0, 1, 5, lat, dat, nstb, fs, fa, oth);
    release_req(0, 1);
    checks++;
    if (lat !== 0 || dat !== init_word(10)) begin
      $display("FAIL dual_m1: got lat %0d dat %h want 0 %h", lat, dat, init_word(10));
      failures++;
    end
  endtask

  task automatic test_write_then_read();
    int lat, nstb, fs, oth;
    logic [31:0] dat, fa, expv;
    do_reset();
    drive(0, 1, 1'b1, 4'b0011, 5, 32'hDEAD_BEEF);
    wait_ack(0, 1, 20, lat, dat, nstb, fs, fa, oth);
    release_req(0, 1);
    checks++;
    if (lat !== 11 || fa !== word_adr(5)) begin
      $display("FAIL wr_ack: got lat %0d adr %h want 11 %h", lat, fa, word_adr(5));
      failures++;
    end
    drive(0, 0, 1'b0, 4'hF, 5, '0);
    wait_ack(0, 0, 20, lat, dat, nstb, fs, fa, oth);
    release_req(0, 0);
    expv = init_word(5);
    expv[15:0] = 16'hBEEF;
    checks++;
    if (lat !== 11 || dat !== expv) begin
      $display("FAIL rd_after_wr: got lat %0d dat %h want 11 %h", lat, dat, expv);
      failures++;
    end
  endtask

  task automatic test_faults();
    int lat, nstb, fs, oth;
    logic [31:0] dat, fa;
    do_reset();
    force_ack[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack[0][0], ack[0][1]} !== 2'b00) begin
      $display("FAIL stray_ack: got %b want 00", {ack[0][0], ack[0][1]}); failures++;
    end
    next_cycle();
    force_ack[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1) begin
      $display("FAIL stray_err: got %b want 1", err[0]); failures++;
    end
    repeat (5) next_cycle();
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1) begin
      $display("FAIL err_sticky: got %b want 1", err[0]); failures++;
    end
    next_cycle();
    do_reset();
    kill[0] = 1'b1;
    drive(0, 0, 1'b0, 4'hF, 3, '0);
    wait_ack(0, 0, 12, lat, dat, nstb, fs, fa, oth);
    kill[0] = 1'b0;
    checks++;
    if (lat !== -1 || nstb !== 1) begin
      $display("FAIL lost_ack: got lat %0d n=%0d want -1 1", lat, nstb); failures++;
    end
    wait_ack(0, 0, 14, lat, dat, nstb, fs, fa, oth);
    release_req(0, 0);
    checks++;
    if (fs !== 0 || lat !== 11 || dat !== init_word(3)) begin
      $display("FAIL retry: got first %0d lat %0d dat %h want 0 11 %h",
               fs, lat, dat, init_word(3));
      failures++;
    end
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1) begin
      $display("FAIL lost_err: got %b want 1", err[0]); failures++;
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    int lat, nstb, fs, oth;
    logic [31:0] dat, fa;
    logic [200:0] outs;
    do_reset();
    drive(0, 0, 1'b0, 4'hF, 1, '0);
    drive(0, 1, 1'b0, 4'hF, 9, '0);
    repeat (5) next_cycle();
    rst_n = 1'b0;
    #1;
    outs = {mem_stb[0], mem_we[0], mem_sel[0], mem_adr[0], mem_wdat[0],
            ack[0][0], ack[0][1], rdat[0][0], rdat[0][1], err[0]};
    checks++;
    if (outs !== '0) begin
      $display("FAIL midreset_outs: got %h want 0", outs); failures++;
    end
    release_req(0, 1);
    drive(0, 0, 1'b0, 4'hF, 7, '0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    wait_ack(0, 0, 20, lat, dat, nstb, fs, fa, oth);
    release_req(0, 0);
    checks++;
    if (fs !== 0 || fa !== word_adr(7) || nstb !== 1) begin
      $display("FAIL post_reset_issue: got first %0d adr %h n=%0d want 0 %h 1",
               fs, fa, nstb, word_adr(7));
      failures++;
    end
    checks++;
    if (lat !== 11 || dat !== init_word(7) || oth !== 0) begin
      $display("FAIL post_reset_ack: got lat %0d dat %h m1acks %0d want 11 %h 0",
               lat, dat, oth, init_word(7));
      failures++;
    end
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b0) begin
      $display("FAIL post_reset_err: got %b want 0", err[0]); failures++;
    end
    next_cycle();
  endtask

  // Each requester runs ntx accesses with random idle gaps; the model
  // tracks who owns the memory slot and when each ack is due.
  task automatic test_traffic(input int d, input int maxgap, input int ntx);
    logic [31:0] gold [16];
    int          left [2];
    int          gap [2];
    int          ack_at [2];
    logic        act [2];
    logic        pend [2];
    logic        tw [2];
    logic [3:0]  ts [2];
    int          tword [2];
    logic [31:0] td [2];
    logic [31:0] exp_d [2];
    logic        e0, e1, g, issue, last, exp_ack;
    int          t;
    do_reset();
    m0_log.delete();
    m1_log.delete();
    for (int k = 0; k < 16; k++) gold[k] = init_word(k);
    for (int i = 0; i < 2; i++) begin
      left[i] = ntx;
      gap[i] = $urandom_range(0, maxgap);
      act[i] = 1'b0;
      pend[i] = 1'b0;
      ack_at[i] = -1;
      exp_d[i] = '0;
    end
    last = 1'b1;
    t = 0;
    while ((left[0] > 0 || left[1] > 0) && t < 3000) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          drive(d, i, 1'($urandom_range(0, 1)), 4'($urandom), 0, $urandom);
          adr[d][i] = $urandom;
          stb[d][i] = 1'b0;
          if (left[i] > 0) begin
            if (gap[i] == 0) begin
              act[i] = 1'b1;
              tw[i] = 1'($urandom_range(0, 1));
              ts[i] = 4'($urandom_range(1, 15));
              tword[i] = i * 8 + $urandom_range(0, 7);
              td[i] = $urandom;
              drive(d, i, tw[i], ts[i], tword[i], td[i]);
            end else begin
              gap[i]--;
            end
          end
        end
      end
      e0 = act[0] && !pend[0];
      e1 = act[1] && !pend[1];
      issue = e0 || e1;
      if (e0 && e1) g = (d == 1) ? 1'b0 : ~last;
      else g = e1;
      @(negedge clk);
      checks++;
      if (mem_stb[d] !== issue) begin
        $display("FAIL traffic%0d_stb t=%0d: got %b want %b", d, t, mem_stb[d], issue);
        failures++;
      end
      checks++;
      if (issue) begin
        if ({mem_we[d], mem_sel[d], mem_adr[d], mem_wdat[d]} !==
            {tw[g], ts[g], word_adr(tword[g]), td[g]}) begin
          $display("FAIL traffic%0d_fields t=%0d: got %b %h %h %h want %b %h %h %h",
                   d, t, mem_we[d], mem_sel[d], mem_adr[d], mem_wdat[d],
                   tw[g], ts[g], word_adr(tword[g]), td[g]);
          failures++;
        end
      end else if ({mem_we[d], mem_sel[d], mem_adr[d], mem_wdat[d]} !== '0) begin
        $display("FAIL traffic%0d_idle t=%0d: got adr %h want 0", d, t, mem_adr[d]);
        failures++;
      end
      for (int i = 0; i < 2; i++) begin
        exp_ack = pend[i] && ack_at[i] == t;
        checks++;
        if (ack[d][i] !== exp_ack) begin
          $display("FAIL traffic%0d_ack%0d t=%0d: got %b want %b", d, i, t, ack[d][i], exp_ack);
          failures++;
        end
        if (exp_ack && !tw[i]) begin
          checks++;
          if (rdat[d][i] !== exp_d[i]) begin
            $display("FAIL traffic%0d_data%0d t=%0d: got %h want %h",
                     d, i, t, rdat[d][i], exp_d[i]);
            failures++;
          end
        end
      end
      if (mem_stb[d]) begin
        if (mem_adr[d][5]) m1_log.push_back(t);
        else m0_log.push_back(t);
      end
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && ack_at[i] == t) begin
          pend[i] = 1'b0;
          act[i] = 1'b0;
          left[i]--;
          gap[i] = $urandom_range(0, maxgap);
        end
      end
      if (issue) begin
        pend[g] = 1'b1;
        ack_at[g] = t + LAT;
        last = g;
        if (!tw[g]) exp_d[g] = gold[tword[g]];
        else
          for (int b = 0; b < 4; b++)
            if (ts[g][b]) gold[tword[g]][8*b +: 8] = td[g][8*b +: 8];
      end
      next_cycle();
      t++;
    end
    checks++;
    if (t >= 3000) begin
      $display("FAIL traffic%0d_timeout: got %0d cycles want < 3000", d, t);
      failures++;
    end
    release_req(d, 0);
    release_req(d, 1);
    @(negedge clk);
    checks++;
    if (err[d] !== 1'b0) begin
      $display("FAIL traffic%0d_err: got %b want 0", d, err[d]); failures++;
    end
    next_cycle();
  endtask

  task automatic test_back_to_back(input int d);
    test_traffic(d, 0, 4);
    checks++;
    if (m0_log.size() != 4 || m1_log.size() != 4) begin
      $display("FAIL b2b%0d_count: got %0d/%0d want 4/4", d, m0_log.size(), m1_log.size());
      failures++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= m0_log.size() || k >= m1_log.size()) begin
        $display("FAIL b2b%0d_slot%0d: got missing issue want %0d/%0d",
                 d, k, 12 * k, 12 * k + 1);
        failures++;
      end else if (m0_log[k] != 12 * k || m1_log[k] != 12 * k + 1) begin
        $display("FAIL b2b%0d_slot%0d: got %0d/%0d want %0d/%0d",
                 d, k, m0_log[k], m1_log[k], 12 * k, 12 * k + 1);
        failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_dual_rr();
    test_back_to_back(0);
    test_back_to_back(1);
    test_write_then_read();
    test_faults();
    test_reset_midflight();
    test_traffic(0, 4, 15);
    test_traffic(1, 4, 15);
    test_traffic(0, 1, 20);
    test_traffic(1, 1, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
